// File: rtl/declet_unpacker.sv
// declet_unpacker: repacks an LSB-first byte stream into 10-bit DPD declets.
// An 18-bit buffer collects bytes at bit position n. The oldest declet sits in
// buf[9:0] and goes out once n reaches 10. A frame ends on the byte marked
// in_last. Any bits that do not fill a whole declet at frame end are dropped
// and raise the sticky misalign flag.
//
// Handshakes: a byte or declet moves on a rising clk edge where its valid and
// ready are both 1. out_declet/out_last are registers, so they hold steady
// while out_valid=1 and out_ready=0. in_ready is the only combinational path
// from an input to an output: it depends on out_ready and rst.
module declet_unpacker #(
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         in_data,
  input  logic               in_valid,
  input  logic               in_last,
  output logic               in_ready,
  output logic [9:0]         out_declet,
  output logic               out_valid,
  output logic               out_last,
  input  logic               out_ready,
  output logic [COUNT_W-1:0] declet_count,
  output logic               misalign
);

  // Buffer state. Bits at position n and above are kept at zero, so a new
  // byte can be ORed in without masking.
  logic [17:0]        r_buf;
  logic [4:0]         r_n;
  logic               r_valid;
  logic               r_pend_last;
  logic               r_misalign;
  logic [COUNT_W-1:0] r_count;

  logic               w_pop;
  logic               w_push;
  logic [17:0]        w_buf_pop;
  logic [4:0]         w_n_pop;
  logic [25:0]        w_ins;
  logic [4:0]         w_n_push;
  logic [17:0]        w_buf_next;
  logic [4:0]         w_n_next;
  logic               w_pend_next;
  logic               w_mis_next;

  assign w_pop  = r_valid & out_ready;
  assign w_push = in_valid & in_ready;

  // A byte is accepted while no frame-final declet is pending and there is room.
  // Room means either fewer than 10 bits are held, or the head declet leaves
  // this cycle.
  assign in_ready     = ~rst & ~r_pend_last & (~r_valid | out_ready);
  assign out_valid    = r_valid;
  assign out_declet   = r_buf[9:0];
  assign out_last     = r_pend_last & r_valid;
  assign declet_count = r_count;
  assign misalign     = r_misalign;

  // Next buffer state. The pop is applied first, then the push lands at the
  // post-pop fill level. While pend_last is set no push can happen, so the
  // pop that clears the frame never coincides with a push.
  always_comb begin
    w_buf_pop   = r_buf;
    w_n_pop     = r_n;
    if (w_pop) begin
      w_buf_pop = {10'b0, r_buf[17:10]};
      w_n_pop   = r_n - 5'd10;
    end
    w_ins       = {18'b0, in_data} << w_n_pop;
    w_n_push    = w_n_pop + 5'd8;
    w_buf_next  = w_buf_pop;
    w_n_next    = w_n_pop;
    w_pend_next = r_pend_last;
    w_mis_next  = r_misalign;
    if (w_pop && r_pend_last) begin
      if (w_n_pop != 5'd0) w_mis_next = 1'b1;
      w_buf_next  = 18'b0;
      w_n_next    = 5'd0;
      w_pend_next = 1'b0;
    end
    if (w_push) begin
      w_buf_next = w_buf_pop | w_ins[17:0];
      w_n_next   = w_n_push;
      if (in_last) begin
        if (w_n_push >= 5'd10) begin
          w_pend_next = 1'b1;
        end else begin
          if (w_n_push != 5'd0) w_mis_next = 1'b1;
          w_buf_next = 18'b0;
          w_n_next   = 5'd0;
        end
      end
    end
  end

  // Register the buffer, the fill count, the frame flags and the declet counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_buf       <= 18'b0;
      r_n         <= 5'd0;
      r_valid     <= 1'b0;
      r_pend_last <= 1'b0;
      r_misalign  <= 1'b0;
      r_count     <= '0;
    end else begin
      r_buf       <= w_buf_next;
      r_n         <= w_n_next;
      r_valid     <= (w_n_next >= 5'd10);
      r_pend_last <= w_pend_next;
      r_misalign  <= w_mis_next;
      if (w_pop) r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_declet_unpacker.sv
// Bench for declet_unpacker using directed frames with hand-computed declets.
// Each expected declet is pushed into exp_q as {out_last, out_declet} when its
// frame is issued. A monitor pops an entry and compares it on every output
// transfer.
module tb_declet_unpacker;

  localparam int CW = 4;

  logic          clk;
  logic          rst;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_last;
  logic          in_ready;
  logic [9:0]    out_declet;
  logic          out_valid;
  logic          out_last;
  logic          out_ready;
  logic [CW-1:0] declet_count;
  logic          misalign;

  logic [10:0]   exp_q[$];
  int            n_checks;
  int            n_errors;

  declet_unpacker #(.COUNT_W(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_last      (in_last),
    .in_ready     (in_ready),
    .out_declet   (out_declet),
    .out_valid    (out_valid),
    .out_last     (out_last),
    .out_ready    (out_ready),
    .declet_count (declet_count),
    .misalign     (misalign)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
    end
  endtask

  // monitor: samples mid low phase, when every driver has settled
  always @(negedge clk) begin
    #2;
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_declet: got=%0h expected=none", {out_last, out_declet});
      end else begin
        check("declet", {21'b0, out_last, out_declet}, {21'b0, exp_q.pop_front()});
      end
    end
  end

  // driver tasks
  task automatic send(input logic [7:0] b, input logic l);
    int   t;
    logic hs;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    in_last  = l;
    t = 0;
    forever begin
      #1 hs = in_ready;
      @(posedge clk);
      if (hs) break;
      t++;
      if (t > 200) begin
        n_checks++;
        n_errors++;
        $display("FAIL send_timeout: got=in_ready_low expected=accept");
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic do_reset();
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    rst      = 1'b1;
    #1;
    check("reset_outputs",
          {14'b0, in_ready, out_valid, out_last, out_declet, declet_count, misalign}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("ready_after_reset", {31'b0, in_ready}, 32'h1);
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    @(negedge clk);
    #3;
    while ((exp_q.size() != 0 || out_valid) && t < 100) begin
      @(negedge clk);
      #3;
      t++;
    end
    check(name, {31'b0, (t >= 100)}, 32'h0);
  endtask

  // Aligned frame: one bit set per 10-bit slot, so every declet is 0x001.
  task automatic frame_aligned();
    exp_q.push_back({1'b0, 10'h001});
    exp_q.push_back({1'b0, 10'h001});
    exp_q.push_back({1'b0, 10'h001});
    exp_q.push_back({1'b1, 10'h001});
    send(8'h01, 1'b0);
    send(8'h04, 1'b0);
    send(8'h10, 1'b0);
    send(8'h40, 1'b0);
    send(8'h00, 1'b1);
    idle();
  endtask

  // Short frame: 16 bits give one declet 0x3FF and 6 discarded bits.
  task automatic frame_short();
    exp_q.push_back({1'b1, 10'h3FF});
    send(8'hFF, 1'b0);
    send(8'hFF, 1'b1);
    idle();
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst       = 1'b1;
    in_data   = 8'h00;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;

    // reset and the aligned frame
    do_reset();
    out_ready = 1'b1;
    frame_aligned();
    drain("aligned_drain");
    check("aligned_misalign", {31'b0, misalign}, 32'h0);
    check("aligned_count", {28'b0, declet_count}, 32'h4);

    // short frame: misalign rises
    frame_short();
    drain("short_drain");
    check("short_misalign", {31'b0, misalign}, 32'h1);
    check("short_count", {28'b0, declet_count}, 32'h5);
    check("short_empty", {31'b0, out_valid}, 32'h0);

    // empty frame, then the next frame must start at bit 0
    do_reset();
    out_ready = 1'b1;
    send(8'hA5, 1'b1);
    idle();
    begin
      logic seen;
      seen = 1'b0;
      repeat (4) begin
        @(negedge clk);
        #1 seen = seen | out_valid;
      end
      check("empty_no_valid", {31'b0, seen}, 32'h0);
    end
    check("empty_misalign", {31'b0, misalign}, 32'h1);
    frame_aligned();
    drain("after_empty_drain");
    check("after_empty_count", {28'b0, declet_count}, 32'h4);

    // backpressure: stall at n=16, then release
    do_reset();
    out_ready = 1'b0;
    exp_q.push_back({1'b0, 10'h3FF});
    exp_q.push_back({1'b0, 10'h3FF});
    exp_q.push_back({1'b1, 10'h3FF});
    send(8'hFF, 1'b0);
    send(8'hFF, 1'b0);
    fork
      begin
        send(8'hFF, 1'b0);
        send(8'hFF, 1'b1);
        idle();
      end
      begin
        repeat (4) begin
          @(negedge clk);
          #1;
          check("stall_in_ready", {31'b0, in_ready}, 32'h0);
          check("stall_hold", {21'b0, out_valid, out_declet}, {21'b0, 1'b1, 10'h3FF});
        end
        @(negedge clk);
        out_ready = 1'b1;
      end
    join
    drain("backpressure_drain");
    check("backpressure_count", {28'b0, declet_count}, 32'h3);
    check("backpressure_misalign", {31'b0, misalign}, 32'h1);

    // reset in the middle of a frame
    do_reset();
    out_ready = 1'b1;
    exp_q.push_back({1'b0, 10'h001});
    send(8'h01, 1'b0);
    send(8'h04, 1'b0);
    send(8'h10, 1'b0);
    do_reset();
    check("midreset_queue", exp_q.size(), 32'h0);
    frame_aligned();
    drain("midreset_drain");
    check("midreset_count", {28'b0, declet_count}, 32'h4);
    check("midreset_misalign", {31'b0, misalign}, 32'h0);

    // counter wrap at 4 bits: 17 declets
    do_reset();
    out_ready = 1'b1;
    repeat (4) frame_aligned();
    frame_short();
    drain("wrap_drain");
    check("wrap_count", {28'b0, declet_count}, 32'h1);
    check("wrap_misalign", {31'b0, misalign}, 32'h1);

    // final report
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/declet_unpacker.md
DECLET_UNPACKER -- requirements
Module: declet_unpacker

Interface
REQ-001 SHALL have parameter COUNT_W, default 16: width of the declet_count status counter.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port in_data, input, 8 bits: packed byte, LSB-first bit order.
REQ-005 SHALL have port in_valid, input, 1 bit: in_data and in_last are valid.
REQ-006 SHALL have port in_last, input, 1 bit: the byte is the final byte of a frame.
REQ-007 SHALL have port in_ready, output, 1 bit: the block accepts a byte this cycle.
REQ-008 SHALL have port out_declet, output, 10 bits: one DPD declet for the downstream decoder.
REQ-009 SHALL have port out_valid, output, 1 bit: out_declet is valid.
REQ-010 SHALL have port out_last, output, 1 bit: the declet is the final declet of a frame.
REQ-011 SHALL have port out_ready, input, 1 bit: the consumer accepts a declet.
REQ-012 SHALL have port declet_count, output, COUNT_W bits: declets transferred since reset, wrapping.
REQ-013 SHALL have port misalign, output, 1 bit: sticky flag, set when a frame ended with discarded residual bits.

Function
REQ-014 SHALL define handshakes as follows: a transfer occurs when valid and ready are both 1 at a clock edge; out_declet and out_last SHALL remain stable while out_valid=1 and out_ready=0.
REQ-015 SHALL hold an 18-bit bit buffer buf and a fill count n (0..17); buf[9:0] is the oldest declet.
REQ-016 SHALL drive out_valid = (n >= 10) and out_declet = buf[9:0] directly from registers.
REQ-017 SHALL drive in_ready = !pend_last && ((n < 10) || out_ready); this is the only combinational input-to-output path.
REQ-018 SHALL, on an output transfer, shift buf right by 10 and reduce n by 10.
REQ-019 SHALL, on an input transfer, write the byte into buf at bit position n (after any same-cycle pop) and increase n by 8.
REQ-020 SHALL, on a simultaneous pop and push, compute n_next = n - 10 + 8; n SHALL never exceed 17.
REQ-021 SHALL set pend_last when a byte with in_last=1 is accepted and n_next >= 10.
REQ-022 SHALL assert out_last = pend_last && (n < 20); since n never reaches 20, out_last is effectively the final declet while pend_last is set.
REQ-023 SHALL, on transfer of a declet with out_last=1, set misalign if the remaining bit count (n - 10) is nonzero, then clear n and pend_last.
REQ-024 SHALL, when a byte with in_last=1 is accepted and n_next < 10, produce no declet, set misalign if n_next is nonzero, and clear n.
REQ-025 SHALL keep in_ready=0 while pend_last=1, so that frames never merge.
REQ-026 SHALL increment declet_count by 1 per output transfer, wrapping modulo 2^COUNT_W.
REQ-027 SHALL treat bits above position n-1 in buf as don't-care; they SHALL never reach out_declet.

Reset
REQ-028 SHALL, while rst=1, asynchronously force buf=0, n=0, pend_last=0, out_valid=0, out_last=0, out_declet=0, in_ready=0, declet_count=0 and misalign=0.
REQ-029 SHALL, after a reset mid-frame, discard all partially accepted bits; in_ready SHALL return to 1 in the first cycle after rst deasserts.

Verification
REQ-030 SHALL verify the aligned frame: bytes 0x01,0x04,0x10,0x40,0x00 (last on the 5th), out_ready=1 -> four declets 0x001, out_last only on the 4th, misalign=0, declet_count=4.
REQ-031 SHALL verify a short frame: bytes 0xFF,0xFF (last), out_ready=1 -> one declet 0x3FF with out_last=1, misalign=1, n=0.
REQ-032 SHALL verify an empty frame: a single byte 0xA5 with last -> no out_valid, misalign=1, and the next frame starts at bit 0.
REQ-033 SHALL verify backpressure: out_ready=0 while streaming 0xFF bytes -> in_ready falls after 2 bytes (n=16), out_declet holds 0x3FF; releasing out_ready resumes with no lost bits.
REQ-034 SHALL verify reset mid-frame: rst pulsed after 3 bytes -> all outputs 0; a following aligned frame reproduces REQ-030 exactly.
REQ-035 SHALL verify counter wrap: with COUNT_W=4, 17 declets transferred -> declet_count=1.
